// File: rtl/srt4_host_adapter.sv
// Host-side sequencer for the srt4 divider: takes one request, drives the divider's
// begin/operand bus, collects quotient and remainder, and returns them on a response channel.
module srt4_host_adapter #(
  parameter int TIMEOUT = 64,
  parameter int QUO_LAG = 0,
  parameter int REM_LAG = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_dividend,
  input  logic [7:0] req_divisor,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_quotient,
  output logic [7:0] rsp_remainder,
  output logic       rsp_dbz,
  output logic       rsp_timeout,
  output logic       div_begin,
  output logic [7:0] div_inbus,
  input  logic [7:0] div_outbus,
  input  logic       div_end
);

  localparam int MAX_LAG = (QUO_LAG > REM_LAG) ? QUO_LAG : REM_LAG;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BEGIN,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_WAIT_END,
    ST_COLLECT,
    ST_RESP
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] dividend_q;
  logic [7:0] divisor_q;
  logic [7:0] quotient_q;
  logic [7:0] remainder_q;
  logic       dbz_q;
  logic       timeout_q;
  logic [7:0] wait_cnt;
  logic [7:0] lag_cnt;
  logic       end_prev;

  logic       fire;
  logic       completion;
  logic       expired;
  logic       collecting;
  logic [7:0] cur_lag;
  logic       cap_quo;
  logic       cap_rem;

  // Lag 0 is the rising-edge cycle itself, which is still spent in WAIT_END.
  always_comb begin
    fire       = req_valid && (state == ST_IDLE);
    completion = (state == ST_WAIT_END) && div_end && !end_prev;
    expired    = (state == ST_WAIT_END) && !completion && (wait_cnt == 8'(TIMEOUT - 1));
    collecting = completion || (state == ST_COLLECT);
    cur_lag    = (state == ST_COLLECT) ? lag_cnt : 8'd0;
    cap_quo    = collecting && (cur_lag == 8'(QUO_LAG));
    cap_rem    = collecting && (cur_lag == 8'(REM_LAG));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (fire) begin
          state_nxt = (req_divisor == 8'd0) ? ST_RESP : ST_BEGIN;
        end
      end
      ST_BEGIN:  state_nxt = ST_LOAD_A;
      ST_LOAD_A: state_nxt = ST_LOAD_B;
      ST_LOAD_B: state_nxt = ST_WAIT_END;
      ST_WAIT_END: begin
        if (completion) begin
          state_nxt = ST_COLLECT;
        end else if (expired) begin
          state_nxt = ST_RESP;
        end
      end
      ST_COLLECT: begin
        if (lag_cnt == 8'(MAX_LAG)) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dividend_q  <= 8'd0;
      divisor_q   <= 8'd0;
      quotient_q  <= 8'd0;
      remainder_q <= 8'd0;
      dbz_q       <= 1'b0;
      timeout_q   <= 1'b0;
      wait_cnt    <= 8'd0;
      lag_cnt     <= 8'd0;
      end_prev    <= 1'b0;
    end else begin
      // History is wiped when an operation starts so only a fresh edge completes it.
      if (fire && (req_divisor != 8'd0)) begin
        end_prev <= 1'b0;
      end else begin
        end_prev <= div_end;
      end

      if (fire) begin
        dividend_q <= req_dividend;
        divisor_q  <= req_divisor;
        timeout_q  <= 1'b0;
        if (req_divisor == 8'd0) begin
          quotient_q  <= 8'hFF;
          remainder_q <= req_dividend;
          dbz_q       <= 1'b1;
        end else begin
          dbz_q <= 1'b0;
        end
      end

      if (state == ST_LOAD_B) begin
        wait_cnt <= 8'd0;
      end else if (state == ST_WAIT_END) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (completion) begin
        lag_cnt <= 8'd1;
      end else if (state == ST_COLLECT) begin
        lag_cnt <= lag_cnt + 8'd1;
      end

      if (cap_quo) begin
        quotient_q <= div_outbus;
      end
      if (cap_rem) begin
        remainder_q <= div_outbus;
      end

      if (expired) begin
        quotient_q  <= 8'd0;
        remainder_q <= 8'd0;
        timeout_q   <= 1'b1;
      end

      if ((state == ST_RESP) && rsp_ready) begin
        dbz_q     <= 1'b0;
        timeout_q <= 1'b0;
      end
    end
  end

  always_comb begin
    req_ready     = (state == ST_IDLE);
    rsp_valid     = (state == ST_RESP);
    div_begin     = (state == ST_BEGIN);
    div_inbus     = 8'd0;
    if (state == ST_LOAD_A) begin
      div_inbus = dividend_q;
    end else if (state == ST_LOAD_B) begin
      div_inbus = divisor_q;
    end
    rsp_quotient  = quotient_q;
    rsp_remainder = remainder_q;
    rsp_dbz       = dbz_q;
    rsp_timeout   = timeout_q;
  end

endmodule

// File: tb/tb_srt4_host_adapter.sv
// Self-checking bench for srt4_host_adapter: a behavioural divider plus an arithmetic
// reference for results and cycle timing, driven by directed and randomized requests.
module tb_srt4_host_adapter;

  localparam int TIMEOUT = 64;
  localparam int QUO_LAG = 0;
  localparam int REM_LAG = 1;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_dividend;
  logic [7:0] req_divisor;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_quotient;
  logic [7:0] rsp_remainder;
  logic       rsp_dbz;
  logic       rsp_timeout;
  logic       div_begin;
  logic [7:0] div_inbus;
  logic [7:0] div_outbus;
  logic       div_end;

  int checks;
  int fails;

  srt4_host_adapter #(
    .TIMEOUT(TIMEOUT),
    .QUO_LAG(QUO_LAG),
    .REM_LAG(REM_LAG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_dividend(req_dividend),
    .req_divisor(req_divisor),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient),
    .rsp_remainder(rsp_remainder),
    .rsp_dbz(rsp_dbz),
    .rsp_timeout(rsp_timeout),
    .div_begin(div_begin),
    .div_inbus(div_inbus),
    .div_outbus(div_outbus),
    .div_end(div_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One full transaction. lat < 0 means the divider never finishes; stale keeps div_end
  // high from before the request into the first two WAIT_END cycles (needs lat >= 3).
  task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b, input int lat,
                                input int stall, input bit stale);
    bit         dbz;
    logic [7:0] exp_q;
    logic [7:0] exp_r;
    int         exp_cyc;
    int         edge_cyc;
    int         cyc;
    int         begins;
    int         rsp_cyc;
    logic [7:0] held_q;
    logic [7:0] held_r;

    dbz      = (b == 8'd0);
    exp_q    = dbz ? 8'hFF : ((lat < 0) ? 8'd0 : a / b);
    exp_r    = dbz ? a     : ((lat < 0) ? 8'd0 : a % b);
    exp_cyc  = dbz ? 1 : ((lat < 0) ? 4 + TIMEOUT : 4 + lat + 1 + 1);
    edge_cyc = 4 + lat;

    check_output("idle_ready", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_dividend = a;
    req_divisor  = b;
    rsp_ready    = 1'b0;
    div_end      = stale;
    div_outbus   = 8'hEE;
    begins       = 0;
    rsp_cyc      = -1;
    cyc          = 0;

    while (cyc < 300) begin
      next_cycle();
      cyc++;
      req_valid = 1'b0;
      if (div_begin) begin
        begins++;
        check_output("begin_cycle", 32'(cyc), 32'd1);
        check_output("begin_inbus", 32'(div_inbus), 32'd0);
      end
      if (!dbz && cyc == 2) check_output("load_a", 32'(div_inbus), 32'(a));
      if (!dbz && cyc == 3) check_output("load_b", 32'(div_inbus), 32'(b));
      if (rsp_valid) begin
        rsp_cyc = cyc;
        break;
      end
      check_output("busy_not_ready", 32'(req_ready), 32'd0);
      div_end = stale && (cyc <= 5);
      if (!dbz && lat >= 0 && cyc >= edge_cyc) div_end = 1'b1;
      if (!dbz && lat >= 0 && cyc == edge_cyc)          div_outbus = a / b;
      else if (!dbz && lat >= 0 && cyc == edge_cyc + 1) div_outbus = a % b;
      else                                              div_outbus = 8'hEE;
    end
    div_outbus = 8'h5A;

    check_output("rsp_seen", 32'(rsp_cyc > 0), 32'd1);
    check_output("rsp_latency", 32'(rsp_cyc), 32'(exp_cyc));
    check_output("begin_count", 32'(begins), dbz ? 32'd0 : 32'd1);
    check_output("rsp_quotient", 32'(rsp_quotient), 32'(exp_q));
    check_output("rsp_remainder", 32'(rsp_remainder), 32'(exp_r));
    check_output("rsp_dbz", 32'(rsp_dbz), 32'(dbz));
    check_output("rsp_timeout", 32'(rsp_timeout), 32'(!dbz && lat < 0));

    if (rsp_cyc < 0) begin
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      next_cycle();
    end else begin
      held_q = rsp_quotient;
      held_r = rsp_remainder;
      for (int s = 0; s < stall; s++) begin
        next_cycle();
        check_output("stall_valid", 32'(rsp_valid), 32'd1);
        check_output("stall_quotient", 32'(rsp_quotient), 32'(held_q));
        check_output("stall_remainder", 32'(rsp_remainder), 32'(held_r));
        check_output("stall_not_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      next_cycle();
      rsp_ready = 1'b0;
      check_output("post_valid", 32'(rsp_valid), 32'd0);
      check_output("post_ready", 32'(req_ready), 32'd1);
      check_output("post_flags", 32'({rsp_dbz, rsp_timeout}), 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: observed simulation still running, expected finish");
    $fatal(1, "[TB] global time limit reached");
  end

  initial begin
    checks       = 0;
    fails        = 0;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_dividend = 8'd0;
    req_divisor  = 8'd0;
    rsp_ready    = 1'b0;
    div_outbus   = 8'd0;
    div_end      = 1'b0;
    next_cycle();
    next_cycle();

    check_output("reset_req_ready", 32'(req_ready), 32'd1);
    check_output("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("reset_div_begin", 32'(div_begin), 32'd0);
    check_output("reset_div_inbus", 32'(div_inbus), 32'd0);
    check_output("reset_rsp_data", 32'({rsp_quotient, rsp_remainder}), 32'd0);
    check_output("reset_rsp_flags", 32'({rsp_dbz, rsp_timeout}), 32'd0);
    rst = 1'b0;
    next_cycle();
    check_output("post_reset_begin", 32'(div_begin), 32'd0);

    $display("[TB] basic divide 100/7");
    apply_stimulus(8'd100, 8'd7, 2, 0, 1'b0);
    $display("[TB] back-pressured 255/16");
    apply_stimulus(8'd255, 8'd16, 1, 5, 1'b0);
    $display("[TB] divide by zero");
    apply_stimulus(8'h2A, 8'd0, 0, 0, 1'b0);
    $display("[TB] divider watchdog");
    apply_stimulus(8'd77, 8'd3, -1, 1, 1'b0);
    $display("[TB] stale div_end level");
    apply_stimulus(8'd9, 8'd3, 4, 0, 1'b1);
    $display("[TB] zero-latency divider");
    apply_stimulus(8'd5, 8'd9, 0, 0, 1'b0);

    $display("[TB] reset during WAIT_END");
    req_valid    = 1'b1;
    req_dividend = 8'd200;
    req_divisor  = 8'd9;
    div_end      = 1'b0;
    next_cycle();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    check_output("midrst_req_ready", 32'(req_ready), 32'd1);
    check_output("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("midrst_div_begin", 32'(div_begin), 32'd0);
    check_output("midrst_rsp_data", 32'({rsp_quotient, rsp_remainder}), 32'd0);
    next_cycle();
    apply_stimulus(8'd50, 8'd5, 3, 0, 1'b0);

    $display("[TB] randomized requests");
    for (int n = 0; n < 25; n++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      int         rlat;
      int         rstall;
      bit         rstale;
      ra     = 8'($urandom_range(0, 255));
      rb     = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      rlat   = $urandom_range(0, 12);
      rstall = $urandom_range(0, 3);
      rstale = (rlat >= 3) && ($urandom_range(0, 1) == 1);
      apply_stimulus(ra, rb, rlat, rstall, rstale);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
